// File: rtl/rr_arb4_16_pkg.sv
// Shared constants and the round-robin pick helper for the 4-source arbiter.
// Holds the default data width, source count and post-reset priority pointer.
package rr_arb4_16_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int NUM_SRC       = 4;

  typedef logic [1:0] src_idx_t;

  // last=3 at reset makes source 0 the first candidate in the scan
  localparam src_idx_t LAST_RESET = 2'd3;

  typedef struct packed {
    logic     found;
    src_idx_t idx;
  } rr_pick_t;

  // Scan last+1, last+2, last+3, last (mod 4); first requester wins.
  // Index falls back to last when nobody requests.
  function automatic rr_pick_t rr_pick(input logic [NUM_SRC-1:0] req,
                                       input src_idx_t last);
    rr_pick_t res;
    src_idx_t cand;
    res.found = 1'b0;
    res.idx   = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last + src_idx_t'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb4_16_if.sv
// Source-side and sink-side handshake bundle for the round-robin arbiter.
// The arbiter uses the slave view; whatever drives sources and sink uses master.
interface rr_arb4_16_if
  import rr_arb4_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [NUM_SRC-1:0] in_valid;
  logic [WIDTH-1:0]   in_data0;
  logic [WIDTH-1:0]   in_data1;
  logic [WIDTH-1:0]   in_data2;
  logic [WIDTH-1:0]   in_data3;
  logic [NUM_SRC-1:0] in_ready;
  src_idx_t           sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  src_idx_t           out_src;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, sel, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, sel, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_arb4_16_mux.sv
// Plain 4-to-1 word multiplexer used for the arbiter's data path.
module m4to1_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb4_16.sv
// Four-source round-robin arbiter with a single registered output word.
// Accepts one word per cycle when the output slot is empty or being drained.
module rr_arb4_16
  import rr_arb4_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  rr_arb4_16_if.slave        bus
);

  src_idx_t         last;
  rr_pick_t         pick;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // Grant depends only on requests, the pointer and output slot occupancy.
  always_comb begin
    load        = !bus.out_valid || bus.out_ready;
    pick        = rr_pick(bus.in_valid, last);
    bus.sel     = pick.idx;
    bus.in_ready = '0;
    if (load && pick.found) begin
      bus.in_ready[pick.idx] = 1'b1;
    end
    xfer = |(bus.in_valid & bus.in_ready);
  end

  m4to1_16 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d0 (bus.in_data0),
    .d1 (bus.in_data1),
    .d2 (bus.in_data2),
    .d3 (bus.in_data3),
    .s  (bus.sel),
    .y  (mux_data)
  );

  // A drained slot with no new grant empties; a stalled slot holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      last          <= LAST_RESET;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= mux_data;
      bus.out_src   <= bus.sel;
      last          <= bus.sel;
    end else if (load) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb4_16.sv
// Directed checks for the round-robin arbiter: rotation, single requester,
// backpressure, async reset, wrap-around and idle drain.
module tb_rr_arb4_16;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  rr_arb4_16_if #(.WIDTH(16)) bus ();

  rr_arb4_16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] valid,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3,
                               input logic ready);
    bus.in_valid  = valid;
    bus.in_data0  = d0;
    bus.in_data1  = d1;
    bus.in_data2  = d2;
    bus.in_data3  = d3;
    bus.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [15:0] data,
                           input logic [1:0] src);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " data"}, 32'(bus.out_data), 32'(data));
    checkOutput({tag, " src"}, 32'(bus.out_src), 32'(src));
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    applyStimulus(4'hF, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    #3;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset out_src", 32'(bus.out_src), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("reset sel", 32'(bus.sel), 32'd0);
    step();
    step();
    rst = 1'b0;

    // all sources requesting: strict rotation starting at source 0
    applyStimulus(4'hF, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    #1;
    checkOutput("rot first in_ready", 32'(bus.in_ready), 32'h1);
    step(); checkWord("rot 0", 16'd1, 2'd0);
    step(); checkWord("rot 1", 16'd2, 2'd1);
    step(); checkWord("rot 2", 16'd3, 2'd2);
    step(); checkWord("rot 3", 16'd4, 2'd3);
    step(); checkWord("rot 4", 16'd1, 2'd0);
    step(); checkWord("rot 5", 16'd2, 2'd1);

    // lone requester on source 2 is granted every cycle
    applyStimulus(4'b0100, 16'd1, 16'd2, 16'h00AA, 16'd4, 1'b1);
    #1;
    checkOutput("single in_ready pre", 32'(bus.in_ready), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      checkWord("single", 16'h00AA, 2'd2);
      checkOutput("single in_ready", 32'(bus.in_ready), 32'h4);
    end

    // backpressure: word from source 0 stalls for three cycles
    applyStimulus(4'b0001, 16'h1111, 16'd2, 16'h00AA, 16'd4, 1'b1);
    #1;
    checkOutput("bp in_ready pre", 32'(bus.in_ready), 32'h1);
    step(); checkWord("bp load", 16'h1111, 2'd0);
    applyStimulus(4'hF, 16'h1111, 16'd2, 16'h00AA, 16'd4, 1'b0);
    #1;
    checkOutput("bp stall in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkWord("bp stall", 16'h1111, 2'd0);
      checkOutput("bp stall in_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(bus.in_ready), 32'h2);
    checkOutput("bp release sel", 32'(bus.sel), 32'd1);
    step(); checkWord("bp next", 16'h0002, 2'd1);

    // async reset between edges drops the held word immediately
    rst = 1'b1;
    #1;
    checkOutput("arst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst out_data", 32'(bus.out_data), 32'd0);
    checkOutput("arst out_src", 32'(bus.out_src), 32'd0);
    checkOutput("arst in_ready", 32'(bus.in_ready), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("arst post in_ready", 32'(bus.in_ready), 32'h1);
    step(); checkWord("arst first", 16'h1111, 2'd0);

    // wrap-around from last=3 with sources 0 and 3 requesting
    rst = 1'b1;
    #1;
    rst = 1'b0;
    applyStimulus(4'b1001, 16'h1111, 16'd2, 16'h00AA, 16'd4, 1'b1);
    #1;
    checkOutput("wrap in_ready 0", 32'(bus.in_ready), 32'h1);
    step(); checkWord("wrap a", 16'h1111, 2'd0);
    checkOutput("wrap in_ready 3", 32'(bus.in_ready), 32'h8);
    step(); checkWord("wrap b", 16'd4, 2'd3);
    step(); checkWord("wrap c", 16'h1111, 2'd0);

    // idle: held word drains, data and pointer stay put
    bus.in_valid = 4'b0000;
    #1;
    checkOutput("idle in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("idle sel", 32'(bus.sel), 32'd0);
    step();
    checkOutput("idle out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle out_data", 32'(bus.out_data), 32'h1111);
    checkOutput("idle out_src", 32'(bus.out_src), 32'd0);
    step();
    checkOutput("idle2 out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle2 sel", 32'(bus.sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arb4_16.md
RR_ARB4_16 -- requirements
Module: rr_arb4_16

Interface
REQ-001 Parameter: WIDTH, 16, data width of every input port and of the output.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  4  per-source request; bit i set means in_data{i} holds a word.
REQ-005 Port: in_data0..in_data3  input  WIDTH each  source words.
REQ-006 Port: in_ready  output  4  per-source accept; at most one bit set per cycle.
REQ-007 Port: sel  output  2  index of the source granted this cycle; drives the select of the 4-to-1 data mux.
REQ-008 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-009 Port: out_data  output  WIDTH  registered selected word.
REQ-010 Port: out_src  output  2  registered index of the source that produced out_data.
REQ-011 Port: out_ready  input  1  downstream accept.

Function
REQ-012 Transfer from source i occurs when in_valid[i] and in_ready[i] are both 1 in the same cycle. Output transfer occurs when out_valid and out_ready are both 1.
REQ-013 load = !out_valid || out_ready. When load is 0, in_ready is 4'b0000.
REQ-014 Round-robin pointer last (2 bits). Scan order is last+1, last+2, last+3, last, all mod 4. The grant goes to the first source with in_valid set.
REQ-015 in_ready[i] = load && grant[i]. This is combinational from in_valid, last and out_valid/out_ready; there is no dependence on in_data.
REQ-016 When a grant exists, sel equals the granted index. With no request, sel holds last.
REQ-017 On a clock edge with an input transfer:
- out_data <= in_data{sel}; out_src <= sel; out_valid <= 1.
- last <= sel.
- Latency is exactly one cycle from input transfer to out_valid.
REQ-018 On a clock edge with load=1 and no input transfer: out_valid <= 0. out_data, out_src and last are unchanged.
REQ-019 When out_valid=1 and out_ready=0, out_data, out_src, out_valid and last hold. No source is accepted.
REQ-020 Simultaneous output consume and new grant in one cycle is required: full throughput of 1 word/cycle.
REQ-021 A single persistent requester is granted every cycle regardless of last.
REQ-022 in_valid may drop without a transfer. The arbiter keeps no memory of requests that were not granted.

Reset
REQ-023 While rst=1, asynchronously:
- out_valid=0, out_data=0, out_src=0
- last=3, so source 0 has first priority after reset
- in_ready follows REQ-015 with out_valid=0
REQ-024 Reset asserted mid-operation discards any held output word without a handshake.

Structure
REQ-025 The shared include header holds:
- the WIDTH default (16)
- the source-count constant (4)
- the reset value of last (3)
REQ-026 Data selection instantiates the existing 16-bit 4-to-1 mux sub-module m4to1_16, with sel as its select. Arbitration and register logic are local to rr_arb4_16.
REQ-027 No latches. All registers sit in one clocked process with asynchronous reset.

Verification
REQ-028 Reset; in_data0..3=1,2,3,4; all in_valid=1; out_ready=1 -> out_data sequence 1,2,3,4,1,2 on consecutive cycles, out_src 0,1,2,3,0,1.
REQ-029 Only in_valid[2]=1, in_data2=16'h00AA, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=16'h00AA, out_src=2 continuously.
REQ-030 Backpressure: transfer in_data0=16'h1111, then out_ready=0 for 3 cycles with all in_valid=1:
- during the stall: out_data=16'h1111, out_valid=1, in_ready=0
- out_ready=1 -> next word is 16'h0002 from source 1
REQ-031 Wrap-around: last=3, in_valid=4'b1001 -> source 0 granted first, then source 3, then source 0.
REQ-032 Assert rst asynchronously between edges while out_valid=1 -> out_valid=0 immediately. After release, the first grant among all-valid sources is source 0.
REQ-033 No requests, out_valid=1, out_ready=1 -> out_valid=0 next cycle; out_data unchanged.
